ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Arbitrates the single shared RAM port among `REQS` cache requesters, such as the icache and dcache of each core in the multicore build. Replaces fixed "data beats instruction" priority with a locked, round-robin grant FSM. It sits between the cache-side request ports and the RAM model. It owns the RAM enables, address and store data, and generates the per-requester wait signals.

## Interface
- `REQS`, 4: number of requesters; index 0 is highest priority after reset.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `WDOG_CYCLES`, 64: watchdog limit in cycles; used only under `RAM_ARB_WDOG_EN`.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `req_ren` in REQS: per-requester read request.
- `req_wen` in REQS: per-requester write request.
- `req_addr` in REQS*ADDR_W: packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_store` in REQS*DATA_W: packed write data, packed the same way.
- `req_wait` out REQS: 0 only in the completing cycle of the granted requester.
- `req_load` out DATA_W: equal to `ramload`, broadcast to all requesters.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out ADDR_W: RAM address.
- `ramstore` out DATA_W: RAM write data.
- `ramload` in DATA_W: RAM read data.
- `ramstate` in 2: `ramstate_t` from `cpu_types_pkg` (FREE, BUSY, ACCESS, ERROR).
- `grant_valid` out 1: a grant is held.
- `grant_id` out $clog2(REQS): index of the granted requester.
- `wdog_err` out 1: one-cycle pulse on watchdog abort; tied to 0 without the macro.

## Operation
- A requester is active when `req_ren[i] | req_wen[i]`.
- FSM states:
  - IDLE: no grant held.
  - GRANT: one requester holds the port.
- **IDLE:**
  - If any requester is active, select the first active index scanning from `rr_ptr` upward, wrapping modulo REQS.
  - Register the selection in `grant_id`, set `grant_valid`, go to GRANT.
  - If no requester is active, stay in IDLE.
- **GRANT:**
  - RAM outputs are driven combinationally from requester `grant_id`.
  - If `req_wen` is set: `ramWEN=1`, `ramREN=0`. The write wins if both enables are set.
  - Otherwise `ramREN = req_ren`.
  - `ramaddr` and `ramstore` come from requester `grant_id`.
- **Completion:**
  - In GRANT with `ramstate==ACCESS` and the granted requester still active: `req_wait[grant_id]=0` for that cycle.
  - Next state is IDLE, and `rr_ptr <= grant_id+1` (wrapping).
- **Abort:**
  - In GRANT with the granted requester inactive: go to IDLE and advance `rr_ptr` as on completion.
  - No wait is deasserted.
- **RAM stalls:**
  - FREE and BUSY: hold the grant and keep waits at 1.
  - ERROR: hold the grant, waits at 1, no state change. Only the watchdog can exit this case.
- **Outputs in IDLE:**
  - `ramREN=0`, `ramWEN=0`, `ramaddr=0`, `ramstore=0`.
  - All `req_wait=1`.
- Grant changes occur only in IDLE, so a transfer is never pre-empted.
- Each completed transfer is followed by at least one IDLE cycle.
- Fairness: an active requester is granted within REQS grants.

## Timing
- **Reset values:**
  - `req_wait` all 1; `ramREN`, `ramWEN`, `ramaddr`, `ramstore` 0.
  - `grant_valid` 0, `grant_id` 0, `rr_ptr` 0, `wdog_err` 0.
  - State is IDLE.
- **Reset mid-transfer:** `RST` high at an edge returns the FSM to IDLE on that edge. RAM enables drop in the following cycle, and no completion is signalled.
- **Latency:**
  - A request first seen in IDLE at cycle t drives the RAM from cycle t+1.
  - With one-cycle ACCESS, `req_wait` is 0 in cycle t+1.
- **Back-to-back throughput:** one transfer per 2 cycles when the RAM latency is 1.
- **Simultaneous requests:** resolved only by `rr_ptr`; reads and writes have no relative priority.
- **`req_load`:** valid in the completing cycle, unregistered.

## Configuration
- Macro: `RAM_ARB_WDOG_EN`.
- **Defined:**
  - A counter clears on entry to GRANT and increments every GRANT cycle without ACCESS.
  - When it reaches `WDOG_CYCLES`, the arbiter returns to IDLE, advances `rr_ptr`, and pulses `wdog_err` for 1 cycle.
  - It also deasserts `req_wait[grant_id]` that cycle, so the requester does not hang; `req_load` is undefined in that cycle.
- **Undefined:** no counter; `wdog_err` is constant 0; a RAM stuck in BUSY or ERROR holds the grant indefinitely.

## Test plan
- **Single read:** REQS=4, requester 2 reads 0x40 with RAM latency 1.
  - `grant_id=2` and `ramREN=1`, `ramaddr=0x40` from cycle t+1.
  - `req_wait[2]=0` in cycle t+1; `req_load` equals `ramload`.
- **Round-robin:** all four requesters active continuously.
  - Grant order is 0,1,2,3,0.
  - Each `req_wait[i]` drops exactly once per 4 transfers.
- **Write precedence:** requester 1 asserts `req_ren` and `req_wen` with data 0xDEADBEEF.
  - `ramWEN=1`, `ramREN=0`, `ramstore=0xDEADBEEF`.
- **Abort:** granted requester 3 drops its request while the RAM is BUSY.
  - IDLE next cycle, no `req_wait` pulse, and the next grant goes to requester 0 if it is active.
- **Mid-transfer reset:** `RST` asserted during BUSY.
  - Next cycle: `ramREN=0`, all waits 1, `grant_valid=0`.
  - A new request is granted to requester 0 first.
- **Watchdog (macro on, `WDOG_CYCLES=8`):** `ramstate` held at BUSY.
  - After 8 GRANT cycles, `wdog_err` pulses for 1 cycle, `req_wait[g]=0`, and the FSM returns to IDLE.
  - With the macro off, the grant is still held after 100 cycles.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the cache requesters, the RAM arbiter and the RAM model.
// slave = arbiter side, master = requester/RAM side.
interface ram_arbiter_if #(
  parameter int REQS   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int IDW = (REQS > 1) ? $clog2(REQS) : 1;

  logic [REQS-1:0]        req_ren;
  logic [REQS-1:0]        req_wen;
  logic [REQS*ADDR_W-1:0] req_addr;
  logic [REQS*DATA_W-1:0] req_store;
  logic [REQS-1:0]        req_wait;
  logic [DATA_W-1:0]      req_load;
  logic                   ramREN;
  logic                   ramWEN;
  logic [ADDR_W-1:0]      ramaddr;
  logic [DATA_W-1:0]      ramstore;
  logic [DATA_W-1:0]      ramload;
  logic [1:0]             ramstate;
  logic                   grant_valid;
  logic [IDW-1:0]         grant_id;
  logic                   wdog_err;

  modport slave (
    input  req_ren, req_wen, req_addr, req_store, ramload, ramstate,
    output req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore,
           grant_valid, grant_id, wdog_err
  );

  modport master (
    output req_ren, req_wen, req_addr, req_store, ramload, ramstate,
    input  req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore,
           grant_valid, grant_id, wdog_err
  );
endinterface

// File: rtl/ram_arbiter.sv
// Locked round-robin arbiter for the shared RAM port; RAM_ARB_WDOG_EN adds a
// watchdog that aborts a grant stuck without ACCESS for WDOG_CYCLES cycles.
//
// state | meaning
// IDLE  | no grant held, RAM outputs idle, all waits high
// GRANT | requester grant_id owns the RAM port until ACCESS or abort
module ram_arbiter #(
  parameter int REQS        = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WDOG_CYCLES = 64
) (
  input logic          CLK,
  input logic          RST,
  ram_arbiter_if.slave bus
);
  localparam int IDW = (REQS > 1) ? $clog2(REQS) : 1;
  localparam logic [1:0] RS_ACCESS = 2'd2;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   sel_id, next_ptr;
  logic             sel_found;
  logic [REQS-1:0]  active;
  logic             g_active, g_access, timeout;
  int               scan_idx;

  assign active   = bus.req_ren | bus.req_wen;
  assign g_active = active[grant_id_q];
  assign g_access = (bus.ramstate == RS_ACCESS);
  assign next_ptr = (int'(grant_id_q) == REQS-1) ? '0 : grant_id_q + 1'b1;

  // First active requester at or after rr_ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    scan_idx  = 0;
    for (int k = 0; k < REQS; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % REQS;
      if (!sel_found && active[scan_idx]) begin
        sel_found = 1'b1;
        sel_id    = IDW'(scan_idx);
      end
    end
  end

`ifdef RAM_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] wdog_cnt_q;

  assign timeout = (state_q == GRANT) && g_active && !g_access &&
                   (int'(wdog_cnt_q) == WDOG_CYCLES - 1);

  always_ff @(posedge CLK) begin
    if (RST || state_q == IDLE) wdog_cnt_q <= '0;
    else if (!g_access)         wdog_cnt_q <= wdog_cnt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    bus.req_wait = '1;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d    = GRANT;
          grant_id_d = sel_id;
        end
      end
      GRANT: begin
        // A write wins when a requester raises both enables.
        bus.ramWEN   = bus.req_wen[grant_id_q];
        bus.ramREN   = bus.req_ren[grant_id_q] & ~bus.req_wen[grant_id_q];
        bus.ramaddr  = bus.req_addr[int'(grant_id_q)*ADDR_W +: ADDR_W];
        bus.ramstore = bus.req_store[int'(grant_id_q)*DATA_W +: DATA_W];
        if (!g_active) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (g_access || timeout) begin
          bus.req_wait[grant_id_q] = 1'b0;
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus.grant_valid = (state_q == GRANT);
  assign bus.grant_id    = grant_id_q;
  assign bus.req_load    = bus.ramload;
  assign bus.wdog_err    = timeout;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized bench for ram_arbiter against a transaction-level
// reference model (current holder, round-robin pointer, watchdog count).
module tb_ram_arbiter;
  localparam int REQS = 4, ADDR_W = 32, DATA_W = 32, WDOG = 8;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if #(.REQS(REQS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
  ram_arbiter #(.REQS(REQS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WDOG_CYCLES(WDOG))
    dut (.CLK(clk), .RST(rst), .bus(bus.slave));

  int ncmp = 0, nerr = 0;
  int m_holder = -1, m_ptr = 0, m_gid = 0, m_cnt = 0;
  bit m_known = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    bus.req_ren   = '0;
    bus.req_wen   = '0;
    bus.req_addr  = '0;
    bus.req_store = '0;
    bus.ramstate  = FREE;
    bus.ramload   = '0;
  endtask

  task automatic set_req(input int i, input bit r, input bit w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_ren[i] = r;
    bus.req_wen[i] = w;
    bus.req_addr[i*ADDR_W +: ADDR_W]  = a;
    bus.req_store[i*DATA_W +: DATA_W] = d;
  endtask

  // Compare every output against the model for the current cycle.
  task automatic settle();
    logic [REQS-1:0]   e_wait;
    logic              e_ren, e_wen, e_to, act;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_store;
    int g;
    #1;
    if (!m_known) return;
    g = m_holder;
    e_wait = '1; e_ren = 0; e_wen = 0; e_to = 0; e_addr = '0; e_store = '0;
    if (g >= 0) begin
      act     = bus.req_ren[g] | bus.req_wen[g];
      e_wen   = bus.req_wen[g];
      e_ren   = bus.req_ren[g] & ~bus.req_wen[g];
      e_addr  = bus.req_addr[g*ADDR_W +: ADDR_W];
      e_store = bus.req_store[g*DATA_W +: DATA_W];
`ifdef RAM_ARB_WDOG_EN
      e_to = act && (bus.ramstate != ACCESS) && (m_cnt + 1 == WDOG);
`endif
      if (act && (bus.ramstate == ACCESS || e_to)) e_wait[g] = 1'b0;
    end
    chk("m_wait",  bus.req_wait,    e_wait);
    chk("m_ren",   bus.ramREN,      e_ren);
    chk("m_wen",   bus.ramWEN,      e_wen);
    chk("m_addr",  bus.ramaddr,     e_addr);
    chk("m_store", bus.ramstore,    e_store);
    chk("m_gv",    bus.grant_valid, (g >= 0));
    chk("m_gid",   bus.grant_id,    m_gid[1:0]);
    chk("m_load",  bus.req_load,    bus.ramload);
    chk("m_wdog",  bus.wdog_err,    e_to);
  endtask

  // Advance one clock and step the model with the inputs of the ending cycle.
  task automatic adv();
    logic [REQS-1:0] act;
    logic [1:0]      st;
    bit found, to;
    int g, j;
    act = bus.req_ren | bus.req_wen;
    st  = bus.ramstate;
    to  = 0;
    g   = m_holder;
`ifdef RAM_ARB_WDOG_EN
    if (g >= 0) to = act[g] && (st != ACCESS) && (m_cnt + 1 == WDOG);
`endif
    @(posedge clk);
    if (rst) begin
      m_holder = -1; m_ptr = 0; m_gid = 0; m_cnt = 0; m_known = 1;
    end else if (m_known) begin
      if (g < 0) begin
        found = 0;
        for (int k = 0; k < REQS; k++) begin
          j = (m_ptr + k) % REQS;
          if (!found && act[j]) begin
            found = 1; m_holder = j; m_gid = j; m_cnt = 0;
          end
        end
      end else if (!act[g] || st == ACCESS || to) begin
        m_ptr = (g + 1) % REQS;
        m_holder = -1;
      end else begin
        m_cnt++;
      end
    end
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  initial begin
    int grants[$];
    int exp_ord[5];
    int drops[REQS];
    bit prev_gv;
    logic [DATA_W-1:0] ld;

    exp_ord = '{0, 1, 2, 3, 0};
    clr_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    settle();
    chk("rst_wait",  bus.req_wait, 4'hF);
    chk("rst_ren",   bus.ramREN, 1'b0);
    chk("rst_wen",   bus.ramWEN, 1'b0);
    chk("rst_addr",  bus.ramaddr, 32'h0);
    chk("rst_store", bus.ramstore, 32'h0);
    chk("rst_gv",    bus.grant_valid, 1'b0);
    chk("rst_gid",   bus.grant_id, 2'd0);
    chk("rst_wdog",  bus.wdog_err, 1'b0);
    adv();

    // Single read by requester 2, one-cycle ACCESS
    ld = $urandom();
    set_req(2, 1, 0, 32'h40, 32'h0);
    bus.ramstate = ACCESS;
    bus.ramload  = ld;
    tick();
    settle();
    chk("rd_gid",  bus.grant_id, 2'd2);
    chk("rd_ren",  bus.ramREN, 1'b1);
    chk("rd_addr", bus.ramaddr, 32'h40);
    chk("rd_wait", bus.req_wait, 4'b1011);
    chk("rd_load", bus.req_load, ld);
    adv();
    clr_in();
    tick();

    // Round-robin with all requesters continuously active
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < REQS; i++) begin
      set_req(i, 1, 0, $urandom(), $urandom());
      drops[i] = 0;
    end
    bus.ramstate = ACCESS;
    prev_gv = 0;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (bus.grant_valid && !prev_gv) grants.push_back(int'(bus.grant_id));
      if (c < 8)
        for (int i = 0; i < REQS; i++) if (!bus.req_wait[i]) drops[i]++;
      prev_gv = bus.grant_valid;
      adv();
    end
    chk("rr_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_order", grants[i], exp_ord[i]);
    for (int i = 0; i < REQS; i++) chk("rr_drops", drops[i], 1);
    clr_in();
    tick();

    // Write precedence on requester 1
    set_req(1, 1, 1, 32'h1234, 32'hDEADBEEF);
    bus.ramstate = BUSY;
    tick();
    settle();
    chk("wp_gid",   bus.grant_id, 2'd1);
    chk("wp_wen",   bus.ramWEN, 1'b1);
    chk("wp_ren",   bus.ramREN, 1'b0);
    chk("wp_store", bus.ramstore, 32'hDEADBEEF);
    adv();
    bus.ramstate = ACCESS;
    tick();
    clr_in();
    tick();

    // Abort: requester 3 drops while BUSY, requester 0 waiting
    set_req(3, 1, 0, 32'h300, 32'h0);
    bus.ramstate = BUSY;
    tick();
    tick();
    set_req(3, 0, 0, 32'h300, 32'h0);
    set_req(0, 1, 0, 32'h0C0, 32'h0);
    settle();
    chk("ab_wait", bus.req_wait, 4'hF);
    chk("ab_gid",  bus.grant_id, 2'd3);
    adv();
    settle();
    chk("ab_idle", bus.grant_valid, 1'b0);
    adv();
    settle();
    chk("ab_next_gv",  bus.grant_valid, 1'b1);
    chk("ab_next_gid", bus.grant_id, 2'd0);
    adv();
    bus.ramstate = ACCESS;
    tick();
    clr_in();
    tick();

    // Reset during a BUSY transfer of requester 2
    set_req(2, 1, 0, 32'h200, 32'h0);
    bus.ramstate = BUSY;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < REQS; i++) set_req(i, 1, 0, 32'h100 + i, 32'h0);
    settle();
    chk("mr_ren",  bus.ramREN, 1'b0);
    chk("mr_wait", bus.req_wait, 4'hF);
    chk("mr_gv",   bus.grant_valid, 1'b0);
    adv();
    settle();
    chk("mr_gid", bus.grant_id, 2'd0);
    chk("mr_gv2", bus.grant_valid, 1'b1);
    adv();
    bus.ramstate = ACCESS;
    tick();
    clr_in();
    tick();

    // RAM stuck in BUSY
    set_req(1, 1, 0, 32'h500, 32'h0);
    bus.ramstate = BUSY;
    tick();
`ifdef RAM_ARB_WDOG_EN
    for (int n = 1; n <= WDOG; n++) begin
      settle();
      if (n < WDOG) chk("wd_quiet", bus.wdog_err, 1'b0);
      else begin
        chk("wd_pulse", bus.wdog_err, 1'b1);
        chk("wd_wait",  bus.req_wait, 4'b1101);
      end
      adv();
    end
    settle();
    chk("wd_idle", bus.grant_valid, 1'b0);
    chk("wd_off",  bus.wdog_err, 1'b0);
    adv();
`else
    repeat (100) tick();
    settle();
    chk("hold_gv",   bus.grant_valid, 1'b1);
    chk("hold_gid",  bus.grant_id, 2'd1);
    chk("hold_wdog", bus.wdog_err, 1'b0);
    adv();
`endif
    clr_in();
    tick();
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < REQS; i++)
        set_req(i, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
                $urandom(), $urandom());
      bus.ramstate = 2'($urandom_range(0, 3));
      bus.ramload  = $urandom();
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
